dmem_slave: RTL and testbench

Single-port data-memory slave that sits directly downstream of the RISC-V CPU's memory request/response channels. It accepts one word-aligned load or byte-strobed store per handshake, services it from an internal SRAM array, and returns load data on the read-data response channel. It is the default data-side target for CPU simulation and FPGA bring-up. A compile-time option injects pseudo-random wait states to stress the CPU's handshake logic.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_lfsr.sv | 15 +
 rtl/dmem_slave.sv | 108 ++++++++++
 tb/tb_dmem_slave.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory slave.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          LFSR_W        = 16;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;  // taps 16,14,13,11
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int          WCNT_W        = 3;
endpackage

// File: rtl/dmem_lfsr.sv
// Fibonacci LFSR used to draw wait states (DMEM_STALL_EN builds only).
module dmem_lfsr
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= seed;
    else if (en) state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
  end
endmodule

// File: rtl/dmem_slave.sv
// Single-port data-memory slave for the CPU data channel.
// Optional wait-state injection is enabled by defining DMEM_STALL_EN.
module dmem_slave
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic        Proto_Err
);
  localparam int NUM_LANES = 4;

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  state_t                state;
  logic [WCNT_W-1:0]     wcnt;
  logic [WCNT_W-1:0]     draw;
  logic                  stall, wr_acc, rd_acc;
  logic                  unused_addr;

  assign idx         = Address[DEPTH_LOG2+1:2];
  assign unused_addr = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

`ifdef DMEM_STALL_EN
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;

  dmem_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign stall       = (MemRead | MemWrite) && (lfsr[1:0] == 2'b00);
  assign draw        = lfsr[4:2];
  assign unused_lfsr = ^lfsr[LFSR_W-1:5];
`else
  logic [15:0] unused_seed;
  assign stall       = 1'b0;
  assign draw        = '0;
  assign unused_seed = LFSR_SEED;
`endif

  assign Mem_Req_Ready = !rst && (state == IDLE) && !stall;
  assign wr_acc        = MemWrite && Mem_Req_Ready;
  // A simultaneous read+write is treated as a store; the load is dropped.
  assign rd_acc        = MemRead && !MemWrite && Mem_Req_Ready;

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int i = 0; i < NUM_LANES; i++)
        if (Write_strb[i]) mem[idx][8*i +: 8] <= Write_data[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wcnt            <= '0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
      Proto_Err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc && MemRead) Proto_Err <= 1'b1;
          if (rd_acc) begin
            Read_data <= mem[idx];
            if (draw == '0) begin
              state           <= RESP;
              Read_data_Valid <= 1'b1;
            end else begin
              state <= WAIT;
              wcnt  <= draw - 1'b1;
            end
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            state           <= RESP;
            Read_data_Valid <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        RESP: begin
          if (Read_data_Ready) begin
            state           <= IDLE;
            Read_data_Valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_slave.sv
// Randomized scoreboard bench for dmem_slave (works with or without DMEM_STALL_EN).
module tb_dmem_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic        Proto_Err;

  int n_chk = 0, n_err = 0, n_stall = 0;
  logic [31:0] model [64];

  dmem_slave #(.DEPTH_LOG2(10), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .MemRead(MemRead),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .Proto_Err(Proto_Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) chk("ready_and_valid", {31'd0, Mem_Req_Ready & Read_data_Valid}, 32'd0);

  // Called at a negedge with a request driven; returns at the accepting posedge.
  task automatic wait_ready();
    int t = 0;
    #1;
    while (!Mem_Req_Ready && t < 50) begin
      n_stall++;
      @(negedge clk); #1;
      t++;
    end
    if (!Mem_Req_Ready) chk("req_timeout", {31'd0, Mem_Req_Ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[7:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    wait_ready();
    model_wr(a, d, s);
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input int hold);
    int lat;
    logic [31:0] exp, first;
    Address = a; MemRead = 1'b1;
    wait_ready();
    exp = model[a[7:2]];
    @(negedge clk);
    MemRead = 1'b0;
    lat = 1;
    while (!Read_data_Valid && lat < 20) begin
      chk("ready_in_wait", {31'd0, Mem_Req_Ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
`ifdef DMEM_STALL_EN
    chk("lat_range", {31'd0, lat >= 1 && lat <= 8}, 32'd1);
`else
    chk("lat", lat, 1);
`endif
    chk("rdata", Read_data, exp);
    chk("ready_in_resp", {31'd0, Mem_Req_Ready}, 32'd0);
    first = Read_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, Read_data_Valid}, 32'd1);
      chk("hold_data", Read_data, first);
      chk("hold_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    end
    Read_data_Ready = 1'b1;
    @(negedge clk);
    Read_data_Ready = 1'b0;
    chk("valid_drop", {31'd0, Read_data_Valid}, 32'd0);
    chk("ready_back", {31'd0, Mem_Req_Ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("rst_valid", {31'd0, Read_data_Valid}, 32'd0);
    chk("rst_perr", {31'd0, Proto_Err}, 32'd0);
    chk("rst_rdata", Read_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("rel_valid", {31'd0, Read_data_Valid}, 32'd0);

    store(32'h10, 32'hDEADBEEF, 4'hF);
    load(32'h10, 0);
    store(32'h10, 32'h000000AA, 4'b0001);
    load(32'h10, 0);
    chk("strb_byte", model[4], 32'hDEADBEAA);
    store(32'h10, 32'hFFFFFFFF, 4'b0000);
    load(32'h10, 5);

    // simultaneous read+write: store wins, no response, sticky error
    Address = 32'h1010; Write_data = 32'h12345678; Write_strb = 4'hF;
    MemWrite = 1'b1; MemRead = 1'b1;
    wait_ready();
    model_wr(32'h1010, 32'h12345678, 4'hF);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("perr_set", {31'd0, Proto_Err}, 32'd1);
    chk("perr_no_resp", {31'd0, Read_data_Valid}, 32'd0);
    @(negedge clk);
    chk("perr_no_resp2", {31'd0, Read_data_Valid}, 32'd0);
    load(32'h10, 0);

    for (int i = 0; i < 64; i++) store(32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 1000; n++) begin
      a = $urandom & 32'hFFFF_F0FF;
      if ($urandom_range(0, 1) == 0) load(a, $urandom_range(0, 2));
      else begin
        d = $urandom; s = 4'($urandom);
        store(a, d, s);
      end
    end
    chk("perr_sticky", {31'd0, Proto_Err}, 32'd1);
`ifdef DMEM_STALL_EN
    chk("stall_seen", {31'd0, n_stall > 0}, 32'd1);
`else
    chk("no_stall", n_stall, 0);
`endif

    // reset during an outstanding load
    Address = 32'h10; MemRead = 1'b1;
    wait_ready();
    @(negedge clk);
    MemRead = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, Read_data_Valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("mid_rst_perr", {31'd0, Proto_Err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("post_rst_valid", {31'd0, Read_data_Valid}, 32'd0);
    chk("post_rst_rdata", Read_data, 32'd0);
    load(32'h10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
